// File: rtl/mdu.sv
// mdu: iterative 32x32 multiply / 32-step restoring divide, {HI,LO} result, ready/stall handshake with EX
// ports: clk, rst (async active-low), start_i, annul_i, aluop_i[7:0], reg1_i, reg2_i -> result_o[63:0], ready_o, stallreq_o
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [7:0]         aluop_i,
  input  logic [WIDTH-1:0]   reg1_i,
  input  logic [WIDTH-1:0]   reg2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, ready_q, ready_d;
  logic [2*WIDTH-1:0] res_q, res_d, prod;
  logic [WIDTH:0] pr, sub;
  logic [WIDTH-1:0] qn, rn, a_abs, b_abs;
  logic is_mul, is_div, sg;
  assign is_mul = aluop_i == EXE_MULT_OP || aluop_i == EXE_MULTU_OP;
  assign is_div = aluop_i == EXE_DIV_OP || aluop_i == EXE_DIVU_OP;
  assign sg = aluop_i == EXE_MULT_OP || aluop_i == EXE_DIV_OP;
  // sign-extend only for signed ops; the low 2*WIDTH bits of the product are then exact
  assign prod = {{WIDTH{sg & reg1_i[WIDTH-1]}}, reg1_i} * {{WIDTH{sg & reg2_i[WIDTH-1]}}, reg2_i};
  assign a_abs = (sg & reg1_i[WIDTH-1]) ? -reg1_i : reg1_i;
  assign b_abs = (sg & reg2_i[WIDTH-1]) ? -reg2_i : reg2_i;
  // rem < divisor always holds, so the borrow bit of sub alone decides pr >= divisor
  assign pr = {rem_q, dvd_q[WIDTH-1]};
  assign sub = pr - {1'b0, dvs_q};
  assign qn = {quot_q[WIDTH-2:0], ~sub[WIDTH]};
  assign rn = sub[WIDTH] ? pr[WIDTH-1:0] : sub[WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quot_d = quot_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    res_d = res_q;
    ready_d = 1'b0;
    if (annul_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          if (is_div && reg2_i != '0) begin
            dvd_d = a_abs;
            dvs_d = b_abs;
            qneg_d = sg & (reg1_i[WIDTH-1] ^ reg2_i[WIDTH-1]);
            rneg_d = sg & reg1_i[WIDTH-1];
            rem_d = '0;
            quot_d = '0;
            cnt_d = '0;
            state_d = DIV;
          end else begin
            res_d = is_mul ? prod : '0;
            ready_d = 1'b1;
            state_d = DONE;
          end
        end
        DIV: begin
          rem_d = rn;
          quot_d = qn;
          dvd_d = dvd_q << 1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            res_d = {rneg_q ? -rn : rn, qneg_q ? -qn : qn};
            ready_d = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          ready_d = start_i;
          state_d = start_i ? DONE : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quot_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      res_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quot_q <= quot_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      res_q <= res_d;
      ready_q <= ready_d;
    end
  end
  assign result_o = res_q;
  assign ready_o = ready_q;
  assign stallreq_o = start_i & ~ready_q & ~annul_i;
endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the execute stage. It consumes the decoded operation (`aluop`) and the two source operands produced by decode, carried through the ID/EX register. The EX stage holds `start_i` while the unit works, and stalls the pipeline through `stallreq_o`. It delivers a 64-bit {HI, LO} result for the EX stage to write into the HI/LO registers.

## Interface
- `WIDTH`, default 32, operand width. Only 32 is supported; the iteration count equals `WIDTH`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  level request from EX. It is held high until EX sees `ready_o`, then dropped.
- `annul_i`  in  1  flush/cancel, e.g. on exception or pipeline flush.
- `aluop_i`  in  8  operation code: `EXE_MULT_OP`, `EXE_MULTU_OP`, `EXE_DIV_OP` or `EXE_DIVU_OP`, as defined in defines.v.
- `reg1_i`  in  32  operand A: multiplicand or dividend (rs).
- `reg2_i`  in  32  operand B: multiplier or divisor (rt).
- `result_o`  out  64  {HI, LO}:
  - multiply: full product.
  - divide: HI = remainder, LO = quotient.
- `ready_o`  out  1  result valid (registered).
- `stallreq_o`  out  1  combinational `start_i & ~ready_o & ~annul_i`.

## Operation
- **State machine:** IDLE, DIV, DONE.
  - Reset: IDLE, `result_o` = 0, `ready_o` = 0, counter = 0.
- **`annul_i`** has priority in every state. The next state is IDLE and `ready_o` is 0 next cycle. `result_o` is held. `annul_i` together with `start_i` in IDLE means the request is not accepted.
- **IDLE** with `start_i` = 1 accepts the request and latches the operands.
  - MULT/MULTU: signed or unsigned 32x32 product is registered into `result_o`; go to DONE.
  - DIV/DIVU with `reg2_i` = 0: `result_o` = 0; go to DONE.
  - DIV/DIVU with nonzero divisor: latch the magnitudes of A and B.
    - For DIV, a negative operand is two's-complement negated; DIVU uses the operands unchanged.
    - Record `qneg` = A[31]^B[31] and `rneg` = A[31] (both 0 for DIVU).
    - Clear the 33-bit partial remainder and counter; go to DIV.
  - Any other `aluop_i`: `result_o` = 0; go to DONE. This prevents a deadlocked stall.
- **DIV** performs one restoring step per cycle, MSB first:
  - Partial remainder = {rem[31:0], next dividend bit}.
  - If it is ≥ |B|, subtract and shift in quotient bit 1; else shift in 0.
  - After the 32nd step (counter 31), apply signs: quotient negated if `qneg`, remainder negated if `rneg`.
  - Load `result_o` = {rem, quot}; go to DONE.
- **DONE:** `ready_o` = 1, and `result_o` is stable. Stay while `start_i` = 1; go to IDLE when `start_i` = 0.
- **Arithmetic rules:**
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
  - Divide by zero gives {0, 0}.
- `result_o` is held outside of result loads.

## Timing
- Request accepted in cycle T (IDLE, `start_i` = 1).
- Multiply, divide-by-zero and unsupported ops: `ready_o` = 1 in T+1. `stallreq_o` is high in T only.
- Divide: DIV occupies T+1..T+32, and `ready_o` = 1 in T+33. `stallreq_o` is high T..T+32, i.e. 33 stall cycles.
- `ready_o` stays high until the first edge with `start_i` = 0. Back-to-back operations therefore need one idle cycle with `start_i` low between them.
- Reset asserted mid-divide returns the unit to IDLE asynchronously. All outputs go to 0 immediately, apart from `stallreq_o`, which follows `start_i`.

## Test plan
- MULT: 0xFFFFFFFE × 0x00000003 → `result_o` = 0xFFFFFFFF_FFFFFFFA, `ready_o` in T+1. MULTU with the same operands → 0x00000002_FFFFFFFA.
- DIV: 0xFFFFFFF9 (−7) / 2 → `ready_o` exactly at T+33, `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}, `stallreq_o` high for 33 cycles. DIVU: 100/7 → {2, 14}.
- Boundaries:
  - DIV 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
  - DIVU 5/0 → {0, 0}, ready in T+1.
  - DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- `annul_i` pulsed at T+10 of a divide → IDLE at T+11, `ready_o` never asserts, `result_o` keeps its prior value. A new DIVU 9/3 afterwards → {0, 3}.
- Hold/handshake: keep `start_i` high 5 cycles after `ready_o` → `ready_o` and `result_o` stable. Drop `start_i` → IDLE next cycle, `ready_o` = 0. Immediately restart → correct new result.
- Drive `rst` low at T+20 of a divide → `result_o` = 0 and `ready_o` = 0 without a clock edge. After release the state is IDLE.
